// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: channel geometry, dwell width
// default and FSM state encoding.
package scan_pkg;

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned DWELL_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t DWELL = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle of the scan sequencer. The mask signal exists only
// when SCAN_MASK_EN is defined.
interface scan_sequencer_if #(
  parameter int unsigned DWELL_W = scan_pkg::DWELL_W_DEF
);
  import scan_pkg::*;

  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  mask;
`endif
  logic [SEL_W-1:0]   data;
  logic               en;
  logic               busy;
  logic               done;
  logic               wrap;

  // Controller side: issues commands, observes the decoder select.
  modport master (
    output start, stop, mode, dwell,
`ifdef SCAN_MASK_EN
    output mask,
`endif
    input  data, en, busy, done, wrap
  );

  // Sequencer side.
  modport slave (
    input  start, stop, mode, dwell,
`ifdef SCAN_MASK_EN
    input  mask,
`endif
    output data, en, busy, done, wrap
  );

endinterface

// File: rtl/scan_next_ch.sv
// Next-channel lookup. With SCAN_MASK_EN it finds the next unmasked channel
// above cur_i (wrapping to the lowest unmasked one), the lowest unmasked
// channel, and whether any channel is unmasked. Without the macro it is a
// plain increment and a test for the top channel.
module scan_next_ch
  import scan_pkg::*;
(
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] mask_i,
`endif
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic [SEL_W-1:0]  first_o,
  output logic              last_o,
  output logic              any_o
);

`ifdef SCAN_MASK_EN
  // Descending scans so the lowest qualifying channel is written last and wins.
  always_comb begin
    first_o = '0;
    any_o   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!mask_i[i]) begin
        first_o = SEL_W'(i);
        any_o   = 1'b1;
      end
    end
    nxt_o  = first_o;
    last_o = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!mask_i[i] && (i > int'(cur_i))) begin
        nxt_o  = SEL_W'(i);
        last_o = 1'b0;
      end
    end
  end
`else
  // Every channel is visited: step by one, last is the top channel.
  always_comb begin
    nxt_o   = cur_i + SEL_W'(1);
    first_o = '0;
    last_o  = (cur_i == SEL_W'(NUM_CH - 1));
    any_o   = 1'b1;
  end
`endif

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: drives a 3-to-8 decoder select through channels in
// ascending order, holding each for dwell+1 cycles, in single or continuous
// mode. Define SCAN_MASK_EN to add a per-channel skip mask.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  scan_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   data_q, data_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;

  logic [SEL_W-1:0]   nxt_ch;
  logic [SEL_W-1:0]   first_ch;
  logic               is_last;
  logic               any_ch;

`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [NUM_CH-1:0]  mask_sel;

  // In IDLE the live mask picks the first channel; mid-sweep the captured one rules.
  always_comb begin
    mask_sel = (state_q == IDLE) ? bus.mask : mask_q;
  end
`endif

  scan_next_ch u_next_ch (
`ifdef SCAN_MASK_EN
    .mask_i  (mask_sel),
`endif
    .cur_i   (data_q),
    .nxt_o   (nxt_ch),
    .first_o (first_ch),
    .last_o  (is_last),
    .any_o   (any_ch)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
`ifdef SCAN_MASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        // stop wins over start; an all-masked start is dropped.
        if (bus.start && !bus.stop && any_ch) begin
          state_d = DWELL;
          data_d  = first_ch;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = bus.dwell;
          dwell_d = bus.dwell;
          mode_d  = bus.mode;
`ifdef SCAN_MASK_EN
          mask_d  = bus.mask;
`endif
        end
      end
      DWELL: begin
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d = dwell_q;
          if (!is_last) begin
            data_d = nxt_ch;
          end else if (mode_q) begin
            data_d = first_ch;
            wrap_d = 1'b1;
          end else begin
            state_d = DONE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
`ifdef SCAN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign bus.data = data_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;

endmodule
